// File: rtl/gf_pkg.sv
// Shared GF(2^n) helpers: field constants, multiplier FSM states and a
// generic xtime function. Ports: none (package).
package gf_pkg;

  localparam int GF_MAX_W = 32;

  localparam logic [7:0]   AES_POLY   = 8'h1b;
  localparam logic [127:0] GHASH_POLY = 128'h87;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } gf_state_e;

  // Multiply v by x in GF(2^w); bits at and above w are discarded.
  function automatic logic [GF_MAX_W-1:0] gf_xt(
    input logic [GF_MAX_W-1:0] v,
    input logic [GF_MAX_W-1:0] poly,
    input int                  w
  );
    logic [GF_MAX_W-1:0] one;
    logic [GF_MAX_W-1:0] mask;
    logic [GF_MAX_W-1:0] r;
    one  = GF_MAX_W'(1);
    mask = (one << w) - one;
    r    = (v << 1) & mask;
    if ((v & (one << (w - 1))) != '0)
      r = r ^ (poly & mask);
    return r;
  endfunction

endpackage

// File: rtl/gf_horner_step.sv
// One MSB-first Horner sub-step: acc_out = xt(acc_in) ^ (b_bit ? a : 0).
// Ports: acc_in, a (W bits), b_bit (1), acc_out (W bits). Combinational.
module gf_horner_step
  import gf_pkg::*;
#(
  parameter int         W    = 8,
  parameter logic [W-1:0] POLY = W'(AES_POLY)
) (
  input  logic [W-1:0] acc_in,
  input  logic [W-1:0] a,
  input  logic         b_bit,
  output logic [W-1:0] acc_out
);

  logic [GF_MAX_W-1:0] xt;

  always_comb begin
    xt      = gf_xt(GF_MAX_W'(acc_in), GF_MAX_W'(POLY), W);
    acc_out = W'(xt) ^ (b_bit ? a : '0);
  end

endmodule

// File: rtl/gf_mul_iter.sv
// Multi-lane iterative GF(2^W) multiplier, BPC multiplier bits per cycle.
// Ports: clk, rst, in_valid/in_ready/in_a/in_b, out_valid/out_ready/out_p.
module gf_mul_iter
  import gf_pkg::*;
#(
  parameter int           W     = 8,
  parameter logic [W-1:0] POLY  = W'(AES_POLY),
  parameter int           LANES = 4,
  parameter int           BPC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_p
);

  localparam int S  = W / BPC;
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  gf_state_e          state_q;
  logic [CW-1:0]      cnt_q;
  logic [LANES*W-1:0] a_q;
  logic [LANES*W-1:0] b_q;
  logic [LANES*W-1:0] acc_q;
  logic               vld_q;

  logic [LANES*W-1:0] acc_d;
  logic [LANES*W-1:0] b_d;

  logic [W-1:0] chain [LANES][BPC+1];

  for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
    assign chain[gl][0] = acc_q[gl*W +: W];
    for (genvar gk = 0; gk < BPC; gk++) begin : g_sub
      gf_horner_step #(
        .W    (W),
        .POLY (POLY)
      ) u_step (
        .acc_in  (chain[gl][gk]),
        .a       (a_q[gl*W +: W]),
        .b_bit   (b_q[gl*W + W-1-gk]),
        .acc_out (chain[gl][gk+1])
      );
    end
    assign acc_d[gl*W +: W] = chain[gl][BPC];
    assign b_d[gl*W +: W]   = b_q[gl*W +: W] << BPC;
  end

  // DONE can hand off and take new operands in one edge.
  assign in_ready  = (state_q == IDLE) |
                     ((state_q == DONE) & out_ready);
  assign out_valid = vld_q;
  assign out_p     = vld_q ? acc_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          b_q   <= b_d;
          if (cnt_q == CW'(S - 1)) begin
            state_q <= DONE;
            vld_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            vld_q <= 1'b0;
            if (in_valid) begin
              a_q     <= in_a;
              b_q     <= in_b;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= BUSY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_mul_iter.sv
// Scoreboard bench for gf_mul_iter: directed vectors, a decoupled monitor,
// plus BPC=2 and W=4 side instances.
module tb_gf_mul_iter;

  localparam int S = 8;

  typedef struct {
    logic [31:0] p;
    int          t;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;

  logic       v2, r2, ov2;
  logic [7:0] a2, b2, p2;
  logic       v3, r3, ov3;
  logic [3:0] a3, b3, p3;

  int   errs;
  int   checks;
  int   cyc;
  bit   side_done;
  bit   waiting;
  exp_t sbq[$];

  gf_mul_iter #(
    .W(8), .POLY(8'h1b), .LANES(4), .BPC(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p)
  );

  gf_mul_iter #(
    .W(8), .POLY(8'h1b), .LANES(1), .BPC(2)
  ) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(v2), .in_ready(r2),
    .in_a(a2), .in_b(b2),
    .out_valid(ov2), .out_ready(1'b1),
    .out_p(p2)
  );

  gf_mul_iter #(
    .W(4), .POLY(4'h3), .LANES(1), .BPC(1)
  ) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(v3), .in_ready(r3),
    .in_a(a3), .in_b(b3),
    .out_valid(ov3), .out_ready(1'b1),
    .out_p(p3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(
    input logic [7:0] l0, input logic [7:0] l1,
    input logic [7:0] l2, input logic [7:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Offer operands; queue expected product on the accepting edge.
  task automatic send(input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] p,
                      input logic        ordy);
    int n;
    @(negedge clk);
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = ordy;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      sbq.push_back('{p: p, t: cyc + 1});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  // Monitor: compares every presented result against the queue head.
  initial waiting = 1'b0;
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      waiting = 1'b0;
    end else if (out_valid) begin
      if (sbq.size() == 0) begin
        errs++;
        checks++;
        $display("FAIL unexpected_out: got %0h expected none", out_p);
      end else begin
        if (!waiting)
          chk("latency", 32'(cyc - sbq[0].t), 32'(S));
        chk("out_p", out_p, sbq[0].p);
        chk("in_ready_done", 32'(in_ready), 32'(out_ready));
        if (out_ready) begin
          void'(sbq.pop_front());
          waiting = 1'b0;
        end else begin
          waiting = 1'b1;
        end
      end
    end
  end

  // Side instances: BPC=2 (sel 0) and W=4, POLY=3 (sel 1).
  initial begin
    logic [7:0] va [4] = '{8'h57, 8'h53, 8'h8, 8'h3};
    logic [7:0] vb [4] = '{8'h83, 8'hca, 8'h2, 8'h3};
    logic [7:0] vp [4] = '{8'hc1, 8'h01, 8'h3, 8'h5};
    int         vs [4] = '{4, 4, 4, 4};
    bit         sel [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int n;
    side_done = 1'b0;
    v2 = 1'b0; a2 = '0; b2 = '0;
    v3 = 1'b0; a3 = '0; b3 = '0;
    @(negedge clk);
    while (rst) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        a3 = va[i][3:0]; b3 = vb[i][3:0]; v3 = 1'b1;
      end else begin
        a2 = va[i]; b2 = vb[i]; v2 = 1'b1;
      end
      @(negedge clk);
      v2 = 1'b0;
      v3 = 1'b0;
      n = 0;
      while (!(sel[i] ? ov3 : ov2) && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk(sel[i] ? "w4_latency" : "bpc2_latency", 32'(n), 32'(vs[i]));
      if (sel[i]) chk("w4_p", 32'(p3), 32'(vp[i][3:0]));
      else        chk("bpc2_p", 32'(p2), 32'(vp[i]));
      @(negedge clk);
    end
    side_done = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    errs = 0;
    checks = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_p", out_p, 32'd0);
    rst = 1'b0;

    // Single lane product, other lanes zero.
    send(pk(8'h57, 0, 0, 0), pk(8'h83, 0, 0, 0),
         pk(8'hc1, 0, 0, 0), 1'b1);
    drain();

    // Four lanes with zero / one / reduction corner cases.
    send(pk(8'h57, 8'h80, 8'h00, 8'hff),
         pk(8'h13, 8'h02, 8'h5a, 8'h01),
         pk(8'hfe, 8'h1b, 8'h00, 8'hff), 1'b1);
    drain();

    send(pk(8'h53, 8'h02, 8'h03, 8'h01),
         pk(8'hca, 8'h80, 8'h03, 8'h01),
         pk(8'h01, 8'h1b, 8'h05, 8'h01), 1'b1);
    drain();

    // Back-to-back: second operand set taken in DONE.
    send(pk(8'h02, 8'h0e, 8'hff, 8'h80),
         pk(8'h87, 8'h01, 8'h00, 8'h80),
         pk(8'h15, 8'h0e, 8'h00, 8'h9a), 1'b1);
    send(pk(8'h57, 8'h57, 8'h57, 8'h57),
         pk(8'h02, 8'h04, 8'h08, 8'h10),
         pk(8'hae, 8'h47, 8'h8e, 8'h07), 1'b1);
    drain();

    // Backpressure, then handshake plus accept on one edge.
    send(pk(8'h57, 8'h57, 0, 0), pk(8'h83, 8'h13, 0, 0),
         pk(8'hc1, 8'hfe, 0, 0), 1'b0);
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    repeat (5) @(negedge clk);
    send(pk(8'h02, 8'h57, 0, 0), pk(8'h87, 8'h83, 0, 0),
         pk(8'h15, 8'hc1, 0, 0), 1'b1);
    drain();

    // in_valid during BUSY must be ignored.
    send(pk(8'h57, 8'h53, 0, 0), pk(8'h13, 8'hca, 0, 0),
         pk(8'hfe, 8'h01, 0, 0), 1'b1);
    @(negedge clk);
    in_a = '1;
    in_b = '1;
    in_valid = 1'b1;
    #1;
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    n = 0;
    while (!side_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("side_done", 32'(side_done), 32'd1);

    // Reset mid-BUSY drops the operation.
    send(pk(8'h57, 8'h11, 8'h22, 8'h33), pk(8'h83, 8'h44, 8'h55, 8'h66),
         32'd0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_p", out_p, 32'd0);

    send(pk(8'h57, 0, 0, 8'h02), pk(8'h13, 0, 0, 8'h87),
         pk(8'hfe, 0, 0, 8'h15), 1'b1);
    drain();
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/gf_mul_iter.md
# gf_mul_iter

Multi-lane iterative GF(2^W) multiplier with valid/ready handshakes. Computes P = A·B mod (x^W + POLY) per lane via MSB-first Horner shift-and-add. Each step is one generalised xtime plus conditional XOR. Sits beside the AES datapath and serves InvMixColumns, key-schedule and GF-hash helpers that need full field multiplies rather than fixed ×2/×3 constants.

## Interface
- W, 8: field width in bits; must be ≥2.
- POLY, 8'h1b: reduction polynomial low-order coefficients (x^W term implicit); W bits.
- LANES, 4: independent multiplier lanes sharing one control FSM.
- BPC, 1: multiplier bits consumed per cycle; must divide W.
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands this cycle.
- in_a  in  LANES*W  multiplicands; lane i at [i*W +: W].
- in_b  in  LANES*W  multipliers; same packing.
- out_valid  out  1  products valid.
- out_ready  in  1  consumer accepts products.
- out_p  out  LANES*W  products; same packing.

## Operation
- S = W/BPC steps per operation.
- States: IDLE, BUSY, DONE. Step counter width clog2(S), max 1 if S=1.
- IDLE: in_ready=1. On in_valid, latch a_r=in_a and b_r=in_b. Clear acc to 0, clear cnt, go BUSY.
- BUSY: each cycle perform BPC sub-steps per lane, MSB first.
  - Sub-step: acc = xt(acc) ^ (b_r[W-1] ? a_r : 0), then b_r <<= 1.
  - xt(v) = (v<<1)[W-1:0] ^ (v[W-1] ? POLY : 0).
- BUSY exit: when cnt==S-1, go DONE; otherwise cnt+1.
- DONE: out_valid=1 and out_p=acc, held stable until out_ready.
  - out_ready=1 and in_valid=0: go IDLE.
  - out_ready=1 and in_valid=1: accept new operands in the same cycle (in_ready=out_ready in DONE), go BUSY.
- in_ready=0 in BUSY; in_valid in BUSY is ignored and never queued.
- Lanes are fully independent arithmetic; one shared FSM, so all lanes complete together.
- Boundary cases:
  - A or B zero gives P=0, with the same latency (no early exit).
  - B=1 gives P=A.
  - Lane with A=B=0 alongside non-zero lanes does not disturb them.
- Arithmetic is pure XOR/shift, with no carries. All intermediates are exactly W bits; bit W is discarded after reduction.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, out_p=0, acc/a_r/b_r/cnt=0.
- rst mid-BUSY or in DONE aborts the operation; the result is lost, with no partial output. Outputs take reset values in the cycle after the rst edge.
- Latency: operands accepted at edge t give out_valid=1 from cycle t+S, i.e. after S BUSY cycles.
- Throughput with out_ready held high: one operation per S+1 cycles.
- out_valid deasserts only after an out_ready handshake edge, or on rst.
- out_p does not change while out_valid=1 and out_ready=0.
- No combinational path from in_* to out_*. in_ready depends combinationally on state and out_ready only.

## Structure
- Shared package gf_pkg:
  - AES_POLY = 8'h1b, GHASH-style constants.
  - State enum {IDLE, BUSY, DONE}.
  - Function gf_xt(v, poly, w) for reuse by other GF blocks.
- Sub-module gf_horner_step (params W, POLY; ports acc_in, a, b_bit, acc_out) is combinational, one per lane per BPC sub-step, chained via a generate loop.
- Top holds the FSM, counter, operand and accumulator registers.

## Test plan
- Defaults, LANES=1, A=0x57, B=0x83 → out_p=0xc1. out_valid rises exactly 8 cycles after the accept edge.
- 4 lanes, A={0x57,0x80,0x00,0xff}, B={0x13,0x02,0x5a,0x01} → {0xfe,0x1b,0x00,0xff}, with all lanes in the same cycle.
- BPC=2, A=0x57, B=0x83 → 0xc1 after 4 cycles. W=4, POLY=4'h3, A=0x8, B=0x2 → 0x3.
- Backpressure: out_ready low for 5 cycles in DONE → out_p stable and in_ready=0. Then out_ready=1 with in_valid=1 (A=0x02, B=0x87) → handshake and accept in the same cycle, next result 0x15.
- in_valid pulsed during BUSY with different operands → ignored; the original product is unaffected.
- rst asserted at BUSY step 3 → next cycle out_valid=0, in_ready=1, out_p=0. A fresh op (A=0x57, B=0x13) then returns 0xfe.
